// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage datapath (IF, ID, EX, MEM, WB).
// Tracks in-flight destination registers, detects RAW hazards against the
// operands decoded in ID, and freezes the pipe while the data bus is busy.
// Optional build macro HAZARD_PERF_EN adds stall/bubble performance counters.
module pipeline_hazard_ctrl #(
  parameter bit RF_WRITE_THROUGH = 1'b0,
  parameter int BUS_TIMEOUT      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_a_reg,
  input  logic [4:0] id_b_reg,
  input  logic       id_a_used,
  input  logic       id_b_used,
  input  logic       id_wb_en,
  input  logic [4:0] id_wb_reg,
  input  logic       bus_wait,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ex_bubble,
  output logic       pipe_freeze,
  output logic       bus_err,
  output logic [1:0] state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_RAW  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Counter value seen on the last permitted wait cycle; the next edge errors out.
  localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic       bus_err_q;
  logic       err_set;
  logic [7:0] wait_cnt;

  // Scoreboard: _p0 = EX, _p1 = MEM, _p2 = WB
  logic       sb_vld_p0, sb_vld_p1, sb_vld_p2;
  logic [4:0] sb_reg_p0, sb_reg_p1, sb_reg_p2;

  logic hit_a;
  logic hit_b;
  logic raw;
  logic frz;

  // A source register hits when a valid older write to it is still in flight.
  // With a write-through register file the WB write is already visible to ID.
  function automatic logic reg_hit(
    input logic [4:0] r,
    input logic       v0,
    input logic [4:0] r0,
    input logic       v1,
    input logic [4:0] r1,
    input logic       v2,
    input logic [4:0] r2
  );
    logic hit;
    hit = (v0 && (r == r0)) || (v1 && (r == r1));
    if (!RF_WRITE_THROUGH) begin
      hit = hit || (v2 && (r == r2));
    end
    return (r != 5'd0) && hit;
  endfunction

  assign hit_a = reg_hit(id_a_reg, sb_vld_p0, sb_reg_p0, sb_vld_p1, sb_reg_p1,
                         sb_vld_p2, sb_reg_p2);
  assign hit_b = reg_hit(id_b_reg, sb_vld_p0, sb_reg_p0, sb_vld_p1, sb_reg_p1,
                         sb_vld_p2, sb_reg_p2);
  assign raw   = id_valid & ((id_a_used & hit_a) | (id_b_used & hit_b));

  // The scoreboard advances only when the back half of the pipe advances.
  assign frz   = (state_q == ST_ERR) | bus_wait;

  // Stall outputs and next state, by priority: freeze, then RAW, then run.
  always_comb begin
    state_d     = ST_RUN;
    err_set     = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ex_bubble   = 1'b0;
    pipe_freeze = 1'b0;
    if (state_q == ST_ERR) begin
      state_d     = ST_ERR;
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      pipe_freeze = 1'b1;
    end else if (bus_wait) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      pipe_freeze = 1'b1;
      if (wait_cnt == TIMEOUT_LAST) begin
        state_d = ST_ERR;
        err_set = 1'b1;
      end else begin
        state_d = ST_WAIT;
      end
    end else if (raw) begin
      state_d    = ST_RAW;
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      ex_bubble  = 1'b1;
    end
    if (rst) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ex_bubble   = 1'b0;
      pipe_freeze = 1'b0;
    end
  end

  // State register and sticky bus error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_q | err_set;
    end
  end

  // Consecutive bus_wait cycle counter, saturating at its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (!bus_wait) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Scoreboard valid bits: ID -> EX (_p0) -> MEM (_p1) -> WB (_p2); a RAW stall
  // injects an invalid bubble into EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_vld_p0 <= 1'b0;
      sb_vld_p1 <= 1'b0;
      sb_vld_p2 <= 1'b0;
    end else if (!frz) begin
      sb_vld_p0 <= id_valid & id_wb_en & (id_wb_reg != 5'd0) & ~raw;
      sb_vld_p1 <= sb_vld_p0;
      sb_vld_p2 <= sb_vld_p1;
    end
  end

  // Scoreboard register numbers: ID -> EX (_p0) -> MEM (_p1) -> WB (_p2);
  // only meaningful when the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (!frz) begin
      sb_reg_p0 <= id_wb_reg;
      sb_reg_p1 <= sb_reg_p0;
      sb_reg_p2 <= sb_reg_p1;
    end
  end

  assign state   = state_q;
  assign bus_err = bus_err_q;

`ifdef HAZARD_PERF_EN
  // Free-running performance counters for PC stalls and EX bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (pc_stall) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (ex_bubble) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances share the stimulus, one with
// RF_WRITE_THROUGH=0 and one with RF_WRITE_THROUGH=1, both with BUS_TIMEOUT=8.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_a_reg;
  logic [4:0] id_b_reg;
  logic       id_a_used;
  logic       id_b_used;
  logic       id_wb_en;
  logic [4:0] id_wb_reg;
  logic       bus_wait;

  logic       pc0, if0, bub0, frz0, err0;
  logic [1:0] st0;
  logic       pc1, if1, bub1, frz1, err1;
  logic [1:0] st1;
`ifdef HAZARD_PERF_EN
  logic [31:0] sc0, bc0, sc1, bc1;
`endif

  int checks = 0;
  int errors = 0;

  // Stimulus word: {rst, valid, a_reg, a_used, b_reg, b_used, wb_en, wb_reg, bus_wait}
  logic [20:0] plan_s[$];
  // Expected word per instance: {pc, ifid, bubble, freeze, bus_err, state[1:0]}
  logic [13:0] plan_e[$];
  logic [13:0] exp_q[$];

  localparam logic [3:0] O_NONE = 4'b0000;
  localparam logic [3:0] O_RAW  = 4'b1110;
  localparam logic [3:0] O_FRZ  = 4'b1101;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.RF_WRITE_THROUGH(1'b0), .BUS_TIMEOUT(8)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_a_reg(id_a_reg),
    .id_b_reg(id_b_reg), .id_a_used(id_a_used), .id_b_used(id_b_used),
    .id_wb_en(id_wb_en), .id_wb_reg(id_wb_reg), .bus_wait(bus_wait),
    .pc_stall(pc0), .ifid_stall(if0), .ex_bubble(bub0), .pipe_freeze(frz0),
    .bus_err(err0), .state(st0)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(sc0), .bubble_count(bc0)
`endif
  );

  pipeline_hazard_ctrl #(.RF_WRITE_THROUGH(1'b1), .BUS_TIMEOUT(8)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_a_reg(id_a_reg),
    .id_b_reg(id_b_reg), .id_a_used(id_a_used), .id_b_used(id_b_used),
    .id_wb_en(id_wb_en), .id_wb_reg(id_wb_reg), .bus_wait(bus_wait),
    .pc_stall(pc1), .ifid_stall(if1), .ex_bubble(bub1), .pipe_freeze(frz1),
    .bus_err(err1), .state(st1)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(sc1), .bubble_count(bc1)
`endif
  );

  function automatic logic [20:0] si(input logic r, input logic v,
                                     input logic [4:0] a, input logic au,
                                     input logic [4:0] b, input logic bu,
                                     input logic we, input logic [4:0] wr,
                                     input logic bw);
    return {r, v, a, au, b, bu, we, wr, bw};
  endfunction

  function automatic logic [20:0] idle_in();
    return si(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endfunction

  function automatic logic [20:0] wr_in(input logic [4:0] r);
    return si(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, r, 1'b0);
  endfunction

  function automatic logic [20:0] rda_in(input logic [4:0] r, input logic bw);
    return si(1'b0, 1'b1, r, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, bw);
  endfunction

  function automatic logic [20:0] bw_in();
    return si(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
  endfunction

  function automatic logic [13:0] x2(input logic [3:0] o0, input logic e0,
                                     input logic [1:0] s0, input logic [3:0] o1,
                                     input logic e1, input logic [1:0] s1);
    return {o0, e0, s0, o1, e1, s1};
  endfunction

  function automatic logic [13:0] xs(input logic [3:0] o, input logic e,
                                     input logic [1:0] s);
    return {o, e, s, o, e, s};
  endfunction

  task automatic plan(input logic [20:0] s, input logic [13:0] e);
    plan_s.push_back(s);
    plan_e.push_back(e);
  endtask

  task automatic apply(input logic [20:0] s);
    {rst, id_valid, id_a_reg, id_a_used, id_b_reg, id_b_used, id_wb_en,
     id_wb_reg, bus_wait} = s;
  endtask

  task automatic test_reset();
    logic [13:0] obs, want;
    int n = 0;
    plan(si(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1), xs(O_NONE, 1'b0, 2'd0));
    plan(si(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1), xs(O_NONE, 1'b0, 2'd0));
    plan(rda_in(5'd5, 1'b0), xs(O_NONE, 1'b0, 2'd0));
    plan(idle_in(), xs(O_NONE, 1'b0, 2'd0));
    while (plan_s.size() > 0) begin
      apply(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      obs  = {pc0, if0, bub0, frz0, err0, st0, pc1, if1, bub1, frz1, err1, st1};
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL reset step %0d: got %b expected %b", n, obs, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw_latency();
    logic [13:0] obs, want;
    int n = 0;
    plan(wr_in(5'd5),          xs(O_NONE, 1'b0, 2'd0));
    plan(rda_in(5'd5, 1'b0),   xs(O_RAW, 1'b0, 2'd0));
    plan(rda_in(5'd5, 1'b0),   xs(O_RAW, 1'b0, 2'd1));
    plan(rda_in(5'd5, 1'b0),   x2(O_RAW, 1'b0, 2'd1, O_NONE, 1'b0, 2'd1));
    plan(rda_in(5'd5, 1'b0),   x2(O_NONE, 1'b0, 2'd1, O_NONE, 1'b0, 2'd0));
    plan(idle_in(),            xs(O_NONE, 1'b0, 2'd0));
    plan(idle_in(),            xs(O_NONE, 1'b0, 2'd0));
    while (plan_s.size() > 0) begin
      apply(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      obs  = {pc0, if0, bub0, frz0, err0, st0, pc1, if1, bub1, frz1, err1, st1};
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL raw_latency step %0d: got %b expected %b", n, obs, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reg0_unused();
    logic [13:0] obs, want;
    int n = 0;
    plan(wr_in(5'd0), xs(O_NONE, 1'b0, 2'd0));
    plan(si(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0), xs(O_NONE, 1'b0, 2'd0));
    plan(wr_in(5'd7), xs(O_NONE, 1'b0, 2'd0));
    plan(si(1'b0, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0), xs(O_NONE, 1'b0, 2'd0));
    plan(si(1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0), xs(O_NONE, 1'b0, 2'd0));
    plan(rda_in(5'd7, 1'b0), x2(O_RAW, 1'b0, 2'd0, O_NONE, 1'b0, 2'd0));
    plan(idle_in(), x2(O_NONE, 1'b0, 2'd1, O_NONE, 1'b0, 2'd0));
    plan(si(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0), xs(O_NONE, 1'b0, 2'd0));
    plan(si(1'b0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0), xs(O_RAW, 1'b0, 2'd0));
    plan(idle_in(), xs(O_NONE, 1'b0, 2'd1));
    plan(idle_in(), xs(O_NONE, 1'b0, 2'd0));
    plan(idle_in(), xs(O_NONE, 1'b0, 2'd0));
    while (plan_s.size() > 0) begin
      apply(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      obs  = {pc0, if0, bub0, frz0, err0, st0, pc1, if1, bub1, frz1, err1, st1};
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL reg0_unused step %0d: got %b expected %b", n, obs, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bus_in_raw();
    logic [13:0] obs, want;
    int n = 0;
    plan(wr_in(5'd5),        xs(O_NONE, 1'b0, 2'd0));
    plan(rda_in(5'd5, 1'b0), xs(O_RAW, 1'b0, 2'd0));
    plan(rda_in(5'd5, 1'b1), xs(O_FRZ, 1'b0, 2'd1));
    plan(rda_in(5'd5, 1'b1), xs(O_FRZ, 1'b0, 2'd2));
    plan(rda_in(5'd5, 1'b0), xs(O_RAW, 1'b0, 2'd2));
    plan(rda_in(5'd5, 1'b0), x2(O_RAW, 1'b0, 2'd1, O_NONE, 1'b0, 2'd1));
    plan(rda_in(5'd5, 1'b0), x2(O_NONE, 1'b0, 2'd1, O_NONE, 1'b0, 2'd0));
    plan(idle_in(),          xs(O_NONE, 1'b0, 2'd0));
    while (plan_s.size() > 0) begin
      apply(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      obs  = {pc0, if0, bub0, frz0, err0, st0, pc1, if1, bub1, frz1, err1, st1};
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL bus_in_raw step %0d: got %b expected %b", n, obs, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    logic [13:0] obs, want;
    int n = 0;
    plan(wr_in(5'd5),        xs(O_NONE, 1'b0, 2'd0));
    plan(rda_in(5'd5, 1'b0), xs(O_RAW, 1'b0, 2'd0));
    plan(rda_in(5'd5, 1'b0), xs(O_RAW, 1'b0, 2'd1));
    plan(si(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0), xs(O_NONE, 1'b0, 2'd0));
    plan(rda_in(5'd5, 1'b0), xs(O_NONE, 1'b0, 2'd0));
    plan(idle_in(),          xs(O_NONE, 1'b0, 2'd0));
    while (plan_s.size() > 0) begin
      apply(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      obs  = {pc0, if0, bub0, frz0, err0, st0, pc1, if1, bub1, frz1, err1, st1};
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL async_reset step %0d: got %b expected %b", n, obs, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [13:0] obs, want;
    int n = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 7; i++) begin
        plan(bw_in(), xs(O_FRZ, 1'b0, (i == 0) ? 2'd0 : 2'd2));
      end
      plan(idle_in(), xs(O_NONE, 1'b0, 2'd2));
    end
    plan(idle_in(), xs(O_NONE, 1'b0, 2'd0));
    for (int i = 0; i < 8; i++) begin
      plan(bw_in(), xs(O_FRZ, 1'b0, (i == 0) ? 2'd0 : 2'd2));
    end
    plan(bw_in(),            xs(O_FRZ, 1'b1, 2'd3));
    plan(idle_in(),          xs(O_FRZ, 1'b1, 2'd3));
    plan(rda_in(5'd5, 1'b0), xs(O_FRZ, 1'b1, 2'd3));
    plan(si(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0), xs(O_NONE, 1'b0, 2'd0));
    plan(idle_in(),          xs(O_NONE, 1'b0, 2'd0));
    while (plan_s.size() > 0) begin
      apply(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      obs  = {pc0, if0, bub0, frz0, err0, st0, pc1, if1, bub1, frz1, err1, st1};
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL timeout step %0d: got %b expected %b", n, obs, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply(si(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));
    @(posedge clk); #1;
    test_reset();
    test_raw_latency();
    test_reg0_unused();
    test_bus_in_raw();
    test_async_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
